// File: rtl/prog_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_mem_loader_pkg
// Shared definitions for the program memory loader: the loader state
// encoding, the default address width and idle instruction byte, and the
// width of the optional running checksum.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
// ---------------------------------------------------------------------------
package prog_mem_loader_pkg;

    // Default program address width; memory depth is 2**ADDR_W bytes.
    localparam int unsigned ADDR_W_DEFAULT = 8;

    // Instruction byte width and the byte fed to the core outside RUN.
    localparam int unsigned INSTR_W            = 8;
    localparam logic [7:0]  IDLE_INSTR_DEFAULT = 8'h00;

    // Width of the running sum kept over the program bytes.
    localparam int unsigned CSUM_W = 8;

    // Loader states. CSUM is only part of the encoding when the checksum
    // stage is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        CSUM = 2'd2,
`endif
        RUN  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/prog_mem_loader_if.sv
// ---------------------------------------------------------------------------
// prog_mem_loader_if
// Bundles the processor-facing and load-facing signals of the loader.
//   pc          : program counter from the core
//   instruction : instruction byte returned for pc
//   loadStart   : one-cycle pulse starting a load
//   loadLen     : byte count for the load (0 means a full 2**ADDR_W bytes)
//   loadData    : program byte
//   loadValid   : loadData is valid
//   loadReady   : loader accepts loadData this cycle
//   cpuHold     : holds the core in reset while high
//   done        : high while the program is running
//   error       : sticky load-failure flag
// master = core/host side, slave = loader side.
// Optional feature macro: LOADER_CHECKSUM_EN (no effect on this file).
// ---------------------------------------------------------------------------
interface prog_mem_loader_if
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) ();

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instruction;
    logic               loadStart;
    logic [ADDR_W-1:0]  loadLen;
    logic [7:0]         loadData;
    logic               loadValid;
    logic               loadReady;
    logic               cpuHold;
    logic               done;
    logic               error;

    modport master (
        output pc, loadStart, loadLen, loadData, loadValid,
        input  instruction, loadReady, cpuHold, done, error
    );

    modport slave (
        input  pc, loadStart, loadLen, loadData, loadValid,
        output instruction, loadReady, cpuHold, done, error
    );

endinterface

// File: rtl/prog_mem_loader_ram.sv
// ---------------------------------------------------------------------------
// prog_ram
// 2**ADDR_W x 8 program storage: synchronous write, asynchronous read.
// Contents are never cleared, so unwritten locations keep their data across
// loads and resets.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
// Optional feature macro: LOADER_CHECKSUM_EN (no effect on this file).
// ---------------------------------------------------------------------------
module prog_ram
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [INSTR_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [INSTR_W-1:0]  rdata_o
);

    logic [INSTR_W-1:0] mem_q [2**ADDR_W];

    // Write port: one byte per enabled cycle, no reset on the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: zero-latency lookup for the core's fetch.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
// Loads a program into on-chip memory over a valid/ready byte stream while
// holding the core in reset, then releases the core and serves instruction
// fetches combinationally.
//   clk_i : system clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : prog_mem_loader_if.slave (pc/instruction, load stream, status)
// Optional feature macro: LOADER_CHECKSUM_EN -- after the program bytes, one
// extra checksum byte is accepted; the load only runs if the 8-bit sum of all
// bytes including it is zero, otherwise error is set and the loader idles.
// ---------------------------------------------------------------------------
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter logic [7:0]  IDLE_INSTR = IDLE_INSTR_DEFAULT
) (
    input logic              clk_i,
    input logic              rst_i,
    prog_mem_loader_if.slave bus
);

    // A zero length field stands for a full memory image.
    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W:0]    recv_q, recv_d;
    logic               loadReadyInt;
    logic               xfer;
    logic               memWe;
    logic [INSTR_W-1:0] ramData;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]  sum_q, sum_d;
    logic [CSUM_W-1:0]  sumCheck;
    logic               error_q, error_d;
`endif

    // The stream is open while bytes or the checksum are expected.
`ifdef LOADER_CHECKSUM_EN
    assign loadReadyInt = (state_q == LOAD) || (state_q == CSUM);
    assign sumCheck     = sum_q + bus.loadData;
`else
    assign loadReadyInt = (state_q == LOAD);
`endif

    assign xfer = bus.loadValid && loadReadyInt;

    // Only program bytes reach memory; the checksum byte is consumed by the
    // check, and reset suppresses a write landing in the same cycle.
    assign memWe = xfer && (state_q == LOAD) && !rst_i;

    prog_ram #(
        .ADDR_W (ADDR_W)
    ) uRam (
        .clk_i   (clk_i),
        .we_i    (memWe),
        .waddr_i (wrAddr_q),
        .wdata_i (bus.loadData),
        .raddr_i (bus.pc),
        .rdata_o (ramData)
    );

    // State register: reset returns to IDLE and clears the load bookkeeping
    // but leaves memory untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wrAddr_q <= '0;
            count_q  <= '0;
            recv_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wrAddr_q <= wrAddr_d;
            count_q  <= count_d;
            recv_q   <= recv_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            error_q  <= error_d;
`endif
        end
    end

    // Next-state logic: a start pulse is honoured from IDLE or RUN, bytes are
    // counted in LOAD until the captured length is reached, and the optional
    // checksum stage decides between RUN and a failed return to IDLE.
    always_comb begin
        state_d  = state_q;
        wrAddr_d = wrAddr_q;
        count_d  = count_q;
        recv_d   = recv_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        error_d  = error_q;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (bus.loadStart) begin
                    state_d  = LOAD;
                    count_d  = (bus.loadLen == '0) ? FULL_LEN : {1'b0, bus.loadLen};
                    wrAddr_d = '0;
                    recv_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = '0;
                    error_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    wrAddr_d = wrAddr_q + ADDR_ONE;
                    recv_d   = recv_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sumCheck;
                    if (recv_d == count_q) begin
                        state_d = CSUM;
                    end
`else
                    if (recv_d == count_q) begin
                        state_d = RUN;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    if (sumCheck == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and fetch outputs are pure decodes of the current state.
    assign bus.loadReady   = loadReadyInt;
    assign bus.cpuHold     = (state_q != RUN);
    assign bus.done        = (state_q == RUN);
    assign bus.instruction = (state_q == RUN) ? ramData : IDLE_INSTR;
`ifdef LOADER_CHECKSUM_EN
    assign bus.error       = error_q;
`else
    assign bus.error       = 1'b0;
`endif

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, meaning program address width; memory depth is 2**ADDR_W bytes.
REQ-002 Parameter IDLE_INSTR, default 8'h00, meaning the instruction byte driven whenever the block is not in RUN.
REQ-003 Oscillator  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PC  input  ADDR_W  program counter from the processor core.
REQ-006 instruction  output  8  instruction byte returned to the core for PC.
REQ-007 LoadStart  input  1  one-cycle pulse that begins a program load.
REQ-008 LoadLen  input  ADDR_W  byte count, sampled when LoadStart is accepted; 0 means 2**ADDR_W.
REQ-009 LoadData  input  8  program byte.
REQ-010 LoadValid  input  1  LoadData is valid.
REQ-011 LoadReady  output  1  block accepts LoadData this cycle.
REQ-012 CpuHold  output  1  holds the core in reset while high.
REQ-013 Done  output  1  high while in RUN.
REQ-014 Error  output  1  sticky load-failure flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, CSUM and RUN; CSUM exists only with LOADER_CHECKSUM_EN.
REQ-016 In IDLE, LoadStart SHALL capture LoadLen into a count register, clear wr_addr to 0, clear Error and enter LOAD on the next edge.
REQ-017 LoadReady SHALL be 1 exactly in LOAD and CSUM, and 0 in IDLE and RUN.
REQ-018 A byte SHALL transfer only on a cycle with LoadValid=1 and LoadReady=1; LoadData SHALL then be written to mem[wr_addr], and wr_addr and the received count SHALL increment.
REQ-019 wr_addr SHALL wrap modulo 2**ADDR_W, and the received count SHALL be ADDR_W+1 bits wide.
REQ-020 After the transfer that makes received equal the captured length, the FSM SHALL enter RUN, or CSUM when LOADER_CHECKSUM_EN is defined, on the next edge.
REQ-021 CpuHold SHALL be 1 in every state except RUN, and SHALL fall on the same edge that RUN is entered.
REQ-022 In RUN, instruction SHALL equal mem[PC] combinationally, with zero-cycle latency; in all other states it SHALL equal IDLE_INSTR.
REQ-023 In RUN, LoadStart SHALL restart the load as in REQ-016, with CpuHold rising on the next edge.
REQ-024 LoadStart SHALL be ignored in LOAD and CSUM.
REQ-025 Memory locations not written by a load SHALL retain their previous contents.
REQ-026 LoadValid outside LOAD and CSUM SHALL have no effect.

Reset
REQ-027 Reset SHALL force state=IDLE, wr_addr=0, count=0 and Error=0, giving CpuHold=1, LoadReady=0, Done=0 and instruction=IDLE_INSTR on the cycle after Reset.
REQ-028 Reset SHALL have priority over LoadStart and over any byte transfer in the same cycle.
REQ-029 Reset SHALL abort a load at any point.
REQ-030 Memory contents SHALL NOT be cleared by Reset.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, an 8-bit running sum SHALL be kept over all program bytes, and CSUM SHALL accept one extra byte.
REQ-032 If the low 8 bits of (sum + checksum byte) are 0, the FSM SHALL enter RUN; otherwise it SHALL set Error=1 and return to IDLE with CpuHold=1.
REQ-033 Without LOADER_CHECKSUM_EN, LOAD SHALL go directly to RUN, no sum logic shall exist, and Error SHALL be constant 0.

Structure
REQ-034 A shared package SHALL hold the state encoding, IDLE_INSTR default, ADDR_W default and the checksum width constant.
REQ-035 One sub-module, prog_ram, SHALL implement the 2**ADDR_W x 8 storage with synchronous write and asynchronous read.
REQ-036 The FSM, counters and checksum logic SHALL reside in prog_mem_loader.

Verification
REQ-037 Reset, then LoadStart with LoadLen=3 and bytes 11,22,33 sent back-to-back:
- LoadReady stays 1 for 3 cycles.
- RUN is entered the next cycle and CpuHold=0.
- PC=0,1,2 reads 11,22,33.
REQ-038 LoadValid toggled 1/0 during a 2-byte load:
- only cycles with LoadValid=1 write.
- Done rises one cycle after the second accepted byte.
REQ-039 LoadLen=0:
- exactly 256 bytes are accepted.
- wr_addr wraps to 0.
- PC=FF reads the last byte.
REQ-040 Reset asserted after 1 of 3 bytes:
- IDLE, CpuHold=1 and instruction=IDLE_INSTR.
- byte 0 remains in memory.
- a new LoadStart restarts at address 0.
REQ-041 With LOADER_CHECKSUM_EN, bytes 01,02 and checksum FD:
- RUN is entered.
- with checksum FE instead, Error=1, the FSM returns to IDLE and CpuHold stays 1.
REQ-042 LoadStart in RUN:
- CpuHold=1 on the next cycle.
- a second LoadStart during LOAD is ignored.
